// File: rtl/multiword_adder_ctrl.sv
// rtl/multiword_adder_ctrl.sv - nibble-serial multiword adder reusing one shared 4-bit adder slice
// Adds one nibble per cycle; the carry between nibbles lives only in carry_q.
module multiword_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic [4*NIBBLES-1:0] s,
  output logic                 cout,
  output logic                 busy,
  output logic                 done
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IDXW-1:0] idx;
  logic            load;
  logic            step;
  logic            last;
  logic [3:0]      slice_a;
  logic [3:0]      slice_b;
  logic [3:0]      slice_sum;
  logic            slice_co;

  assign last = (idx == LAST_IDX);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: operands stay frozen
        step = 1'b1;
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    slice_a = 4'd0;
    slice_b = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDXW'(i)) begin
        slice_a = a_q[4*i +: 4];
        slice_b = b_q[4*i +: 4];
      end
    end
  end

  // The single shared slice: 4-bit a/b plus carry register in, 4-bit sum plus carry out.
  assign {slice_co, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, carry_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      s       <= '0;
      cout    <= 1'b0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx     <= '0;
      s       <= '0;
      cout    <= 1'b0;
    end else if (step) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx == IDXW'(i)) begin
          s[4*i +: 4] <= slice_sum;
        end
      end
      carry_q <= slice_co;
      if (last) begin
        cout <= slice_co;
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// tb/tb_multiword_adder_ctrl.sv - directed and random self-checking bench for multiword_adder_ctrl
module tb_multiword_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] s;
  logic        cout;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  multiword_adder_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; pulses start for one edge and waits for done.
  task automatic do_add(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                        output logic [15:0] rs, output logic rc, output int nbusy,
                        output logic got, output logic [15:0] s0);
    start = 1'b1;
    a = va;
    b = vb;
    cin = vc;
    @(posedge clk);
    #1;
    start = 1'b0;
    s0 = s;
    nbusy = 0;
    got = 1'b0;
    rs = '0;
    rc = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) begin
        got = 1'b1;
        rs = s;
        rc = cout;
      end else begin
        if (busy) nbusy++;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s, cout, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: s=%h cout=%b busy=%b done=%b, required all zero", s, cout, busy, done);
    end
  endtask

  task automatic test_basic();
    logic [15:0] rs, s0;
    logic rc, got;
    int nb;
    rst_n = 1'b1;
    do_add(16'h1234, 16'h4321, 1'b0, rs, rc, nb, got, s0);
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: done seen=%b, required 1", got);
    end
    checks++;
    if (nb !== 4) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, required 4", nb);
    end
    checks++;
    if ({rc, rs} !== 17'h05555) begin
      errors++;
      $display("FAIL basic_sum: got cout=%b s=%h, required cout=0 s=5555", rc, rs);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || s !== 16'h5555) begin
      errors++;
      $display("FAIL basic_after_done: done=%b busy=%b s=%h, required done=0 busy=0 s=5555", done, busy, s);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] rs, s0;
    logic rc, got;
    int nb;
    do_add(16'hFFFF, 16'h0001, 1'b0, rs, rc, nb, got, s0);
    checks++;
    if (s0 !== 16'h0000) begin
      errors++;
      $display("FAIL clear_on_start: s=%h, required 0000", s0);
    end
    checks++;
    if (got !== 1'b1 || {rc, rs} !== 17'h10000) begin
      errors++;
      $display("FAIL ripple_all: got done=%b cout=%b s=%h, required done=1 cout=1 s=0000", got, rc, rs);
    end
    @(posedge clk);
    #1;
    do_add(16'hE8D7, 16'h9373, 1'b1, rs, rc, nb, got, s0);
    checks++;
    if (got !== 1'b1 || {rc, rs} !== 17'h17C4B) begin
      errors++;
      $display("FAIL mixed_cin: got done=%b cout=%b s=%h, required done=1 cout=1 s=7c4b", got, rc, rs);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [4] = '{16'h0F0F, 16'hFFFF, 16'h8000, 16'h1234};
    logic [15:0] vb [4] = '{16'h00F1, 16'hFFFF, 16'h8000, 16'h0000};
    logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [16:0] expv [4] = '{17'h01000, 17'h1FFFF, 17'h10000, 17'h01235};
    int cyc;
    int nonbusy;
    logic got;
    start = 1'b1;
    a = va[0];
    b = vb[0];
    cin = vc[0];
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      cyc = 0;
      nonbusy = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
        if (done) begin
          got = 1'b1;
        end else begin
          if (!busy) nonbusy++;
          a = 16'($urandom);
          b = 16'($urandom);
          cin = 1'($urandom);
          @(posedge clk);
          #1;
          cyc++;
        end
      end
      checks++;
      if (got !== 1'b1 || cyc !== 4 || nonbusy !== 0) begin
        errors++;
        $display("FAIL b2b_timing[%0d]: done=%b cycles=%0d idle_in_run=%0d, required done=1 cycles=4 idle_in_run=0", j, got, cyc, nonbusy);
      end
      checks++;
      if ({cout, s} !== expv[j] || busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_result[%0d]: cout=%b s=%h busy=%b, required %h busy=0", j, cout, s, busy, expv[j]);
      end
      if (j < 3) begin
        a = va[j+1];
        b = vb[j+1];
        cin = vc[j+1];
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {cout, s} !== 17'h01235) begin
      errors++;
      $display("FAIL b2b_end: done=%b busy=%b cout=%b s=%h, required done=0 busy=0 01235", done, busy, cout, s);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] rs, s0;
    logic rc, got;
    int nb;
    int saw_done;
    start = 1'b1;
    a = 16'h1111;
    b = 16'h1111;
    cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s !== 16'h0022 || busy !== 1'b1) begin
      errors++;
      $display("FAIL partial_sum: s=%h busy=%b, required s=0022 busy=1", s, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s, cout, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: s=%h cout=%b busy=%b done=%b, required all zero", s, cout, busy, done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done++;
    end
    checks++;
    if (saw_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done: busy/done cycles=%0d, required 0", saw_done);
    end
    do_add(16'h0000, 16'h0001, 1'b0, rs, rc, nb, got, s0);
    checks++;
    if (got !== 1'b1 || {rc, rs} !== 17'h00001) begin
      errors++;
      $display("FAIL after_reset_add: done=%b cout=%b s=%h, required done=1 cout=0 s=0001", got, rc, rs);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [15:0] ca [6] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    logic [15:0] cb [6] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic        cc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] va, vb, rs, s0;
    logic vc, rc, got;
    logic [16:0] expv;
    int nb;
    int bad = 0;
    for (int n = 0; n < 1000; n++) begin
      if (n < 6) begin
        va = ca[n];
        vb = cb[n];
        vc = cc[n];
      end else begin
        va = 16'($urandom);
        vb = 16'($urandom);
        vc = 1'($urandom);
      end
      expv = {1'b0, va} + {1'b0, vb} + {16'd0, vc};
      do_add(va, vb, vc, rs, rc, nb, got, s0);
      checks++;
      if (got !== 1'b1 || {rc, rs} !== expv || nb !== 4) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: a=%h b=%h cin=%b got done=%b %b_%h busy=%0d, required %h busy=4", n, va, vb, vc, got, rc, rs, nb, expv);
      end
      if ((n % 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiword_adder_ctrl.md
MULTIWORD_ADDER_CTRL -- requirements
Module: multiword_adder_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand; W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled on clk.
REQ-005 SHALL have port a  input  W  first operand, captured when start is accepted.
REQ-006 SHALL have port b  input  W  second operand, captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in, captured when start is accepted.
REQ-008 SHALL have port s  output  W  registered sum.
REQ-009 SHALL have port cout  output  1  registered final carry-out.
REQ-010 SHALL have port busy  output  1  high while nibbles are being processed.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking s/cout valid.

Function
REQ-012 SHALL compute {cout,s} = a + b + cin (W+1 bits, unsigned) using exactly one shared combinational 4-bit adder slice (4-bit a/b, cin, 4-bit sum, cout) reused once per cycle.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; encoding free.
REQ-014 IDLE: start=1 -> capture a, b, cin into operand/carry registers; clear s and cout to 0; nibble index idx=0; go RUN.
REQ-015 IDLE: start=0 -> stay IDLE; s and cout hold.
REQ-016 RUN: each cycle slice adds nibble idx of captured a and b with carry register; result written to s[4*idx+3:4*idx]; slice carry-out written to carry register; idx increments.
REQ-017 RUN: on the cycle idx=NIBBLES-1 is processed, the slice carry-out SHALL load cout and the FSM SHALL go DONE.
REQ-018 DONE: done=1 for exactly this one cycle; s and cout hold final values; go IDLE unless start=1.
REQ-019 DONE with start=1 SHALL be accepted as in REQ-014 (back-to-back operation, no idle gap) and go RUN.
REQ-020 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; both registered/state-decoded, no combinational path from start.
REQ-021 Latency: start accepted at edge k -> busy high after edges k..k+NIBBLES-1 -> done high in cycle following edge k+NIBBLES; s/cout valid from that cycle until next accepted start.
REQ-022 start while in RUN SHALL be ignored; captured operands SHALL not change; a/b/cin changes during RUN SHALL not affect the result.
REQ-023 Carry SHALL propagate between nibbles only through the carry register (one nibble per cycle, never combinationally across nibbles).
REQ-024 idx SHALL be ceil(log2(NIBBLES)) bits minimum and SHALL not wrap inside RUN; it resets to 0 on every accepted start.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force state IDLE, s=0, cout=0, busy=0, done=0, idx=0, operand and carry registers 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL wait in IDLE for a new start.
REQ-027 start high during the first edge after rst_n release SHALL be accepted normally.

Verification (NIBBLES=4)
REQ-028 a=0x1234, b=0x4321, cin=0, 1-cycle start -> busy high 4 cycles, done pulse 1 cycle, s=0x5555, cout=0.
REQ-029 a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1 (carry ripples through all 4 nibble cycles).
REQ-030 a=0xE8D7, b=0x9373, cin=1 -> s=0x7C4B, cout=1.
REQ-031 start held high continuously with new operands each DONE cycle -> back-to-back results every 5 cycles, busy low only in DONE cycles; start pulses during RUN do not alter result.
REQ-032 rst_n pulsed low 2 cycles into RUN -> outputs zero immediately, no done pulse; subsequent start with a=0x0000, b=0x0001, cin=0 -> s=0x0001, cout=0.
REQ-033 Self-checking bench SHALL compare s/cout against a+b+cin reference for 1000 random operand/cin sets, including all-ones and all-zeros corners.
